// File: rtl/goomba_pkg.sv
// Shared types and helpers for the Goomba slot scheduler.
//   slot_state_t   : per-slot lifecycle FREE -> LOAD -> ACTIVE -> DYING -> FREE
//   KILL_X_DEFAULT : x coordinate a mover reports once its Goomba is stomped
//   sat_add16      : 16-bit saturating add of a wide increment
package goomba_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    DYING  = 2'd3
  } slot_state_t;

  localparam int KILL_X_DEFAULT = 1000;

  // Saturates at 16'hFFFF; b is wide so multiplied increments cannot wrap first.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {17'd0, a} + {1'b0, b};
    if (sum > 33'h0_0000_FFFF) return 16'hFFFF;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/goomba_slot_fsm.sv
// One Goomba mover slot: lifecycle FSM, shared hold/despawn down-counter and
// the latched spawn position.
// Ports:
//   movement_clock, reset     : clock, synchronous active-high reset
//   alloc                     : this slot was picked for a spawn this cycle
//   freeze                    : game is over; ACTIVE slots no longer leave ACTIVE
//   spawn_x, spawn_y          : spawn position, latched when alloc is high
//   goomba_x, goomba_lose     : mover status, only honoured while ACTIVE
//   state                     : current FSM state (debug / allocator)
//   slot_reset_n, slot_active : active-low mover reset, ACTIVE indicator
//   x_initial, y_initial      : latched spawn position for the mover
//   kill_event, lose_event    : stomp / side-touch seen while ACTIVE
module goomba_slot_fsm
  import goomba_pkg::*;
#(
  parameter int RESET_HOLD     = 2,
  parameter int DESPAWN_CYCLES = 30,
  parameter int KILL_X         = KILL_X_DEFAULT
) (
  input  logic        movement_clock,
  input  logic        reset,
  input  logic        alloc,
  input  logic        freeze,
  input  logic [31:0] spawn_x,
  input  logic [31:0] spawn_y,
  input  logic [31:0] goomba_x,
  input  logic        goomba_lose,
  output slot_state_t state,
  output logic        slot_reset_n,
  output logic        slot_active,
  output logic [31:0] x_initial,
  output logic [31:0] y_initial,
  output logic        kill_event,
  output logic        lose_event
);

  // Counter is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [15:0] HOLD_LOAD    = 16'(RESET_HOLD - 1);
  localparam logic [15:0] DESPAWN_LOAD = 16'(DESPAWN_CYCLES - 1);

  slot_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge movement_clock) begin
    if (reset) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      x_initial <= '0;
      y_initial <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (alloc) begin
        x_initial <= spawn_x;
        y_initial <= spawn_y;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kill_event = 1'b0;
    lose_event = 1'b0;
    case (state_q)
      FREE: begin
        if (alloc) begin
          state_d = LOAD;
          cnt_d   = HOLD_LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == 16'd0) state_d = ACTIVE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      ACTIVE: begin
        lose_event = goomba_lose;
        // Once frozen the mover is expected to stop, so a stomp is no longer taken.
        kill_event = (goomba_x == 32'(KILL_X)) && !freeze;
        if (kill_event) begin
          state_d = DYING;
          cnt_d   = DESPAWN_LOAD;
        end
      end
      DYING: begin
        if (cnt_q == 16'd0) state_d = FREE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = FREE;
    endcase
  end

  assign state        = state_q;
  assign slot_active  = (state_q == ACTIVE);
  assign slot_reset_n = (state_q == ACTIVE);

endmodule

// File: rtl/goomba_slot_scheduler.sv
// Owns NUM_SLOTS Goomba mover slots: allocates spawns to the lowest FREE slot,
// aggregates lose flags into a sticky game_over and counts stomps.
// Optional feature macro: GOOMBA_SCORE_EN adds output score and parameter
// POINTS_PER_KILL (score += POINTS_PER_KILL per counted kill, saturating).
// Handshake: a spawn transfers on a rising edge where spawn_valid && spawn_ready;
// spawn_ready depends only on registered state, never on spawn_valid.
// Ports:
//   movement_clock, reset          : clock, synchronous active-high reset
//   spawn_valid/ready, spawn_x/y   : spawn request handshake and position
//   goomba_x_slot, goomba_lose_slot: per-mover status
//   slot_reset_n, slot_active      : per-mover reset (active low), ACTIVE flag
//   slot_x_initial, slot_y_initial : per-mover spawn position
//   game_over, kill_count          : sticky lose flag, saturating stomp count
module goomba_slot_scheduler
  import goomba_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int RESET_HOLD     = 2,
  parameter int DESPAWN_CYCLES = 30,
  parameter int KILL_X         = KILL_X_DEFAULT
`ifdef GOOMBA_SCORE_EN
  , parameter int POINTS_PER_KILL = 100
`endif
) (
  input  logic                      movement_clock,
  input  logic                      reset,
  input  logic                      spawn_valid,
  output logic                      spawn_ready,
  input  logic [31:0]               spawn_x,
  input  logic [31:0]               spawn_y,
  input  logic [NUM_SLOTS-1:0][31:0] goomba_x_slot,
  input  logic [NUM_SLOTS-1:0]      goomba_lose_slot,
  output logic [NUM_SLOTS-1:0]      slot_reset_n,
  output logic [NUM_SLOTS-1:0][31:0] slot_x_initial,
  output logic [NUM_SLOTS-1:0][31:0] slot_y_initial,
  output logic [NUM_SLOTS-1:0]      slot_active,
  output logic                      game_over,
  output logic [15:0]               kill_count
`ifdef GOOMBA_SCORE_EN
  , output logic [15:0]             score
`endif
);

  slot_state_t            slot_state [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   slot_free;
  logic [NUM_SLOTS-1:0]   alloc;
  logic [NUM_SLOTS-1:0]   kill_event;
  logic [NUM_SLOTS-1:0]   lose_event;
  logic [31:0]            kill_num;
  logic                   kills_counted;
  logic                   found;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    goomba_slot_fsm #(
      .RESET_HOLD     (RESET_HOLD),
      .DESPAWN_CYCLES (DESPAWN_CYCLES),
      .KILL_X         (KILL_X)
    ) u_fsm (
      .movement_clock (movement_clock),
      .reset          (reset),
      .alloc          (alloc[g]),
      .freeze         (game_over),
      .spawn_x        (spawn_x),
      .spawn_y        (spawn_y),
      .goomba_x       (goomba_x_slot[g]),
      .goomba_lose    (goomba_lose_slot[g]),
      .state          (slot_state[g]),
      .slot_reset_n   (slot_reset_n[g]),
      .slot_active    (slot_active[g]),
      .x_initial      (slot_x_initial[g]),
      .y_initial      (slot_y_initial[g]),
      .kill_event     (kill_event[g]),
      .lose_event     (lose_event[g])
    );
    assign slot_free[g] = (slot_state[g] == FREE);
  end

  assign spawn_ready = (|slot_free) && !game_over;

  // Lowest-index FREE slot wins; at most one alloc bit is ever set.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_free[i] && !found) begin
        alloc[i] = spawn_valid && spawn_ready;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    kill_num = '0;
    for (int i = 0; i < NUM_SLOTS; i++) kill_num = kill_num + 32'(kill_event[i]);
  end

  // A lose in the same cycle wins over any kill: nothing is counted.
  assign kills_counted = !game_over && !(|lose_event);

  always_ff @(posedge movement_clock) begin
    if (reset) begin
      game_over  <= 1'b0;
      kill_count <= '0;
    end else begin
      if (|lose_event)   game_over  <= 1'b1;
      if (kills_counted) kill_count <= sat_add16(kill_count, kill_num);
    end
  end

`ifdef GOOMBA_SCORE_EN
  always_ff @(posedge movement_clock) begin
    if (reset)              score <= '0;
    else if (kills_counted) score <= sat_add16(score, 32'(POINTS_PER_KILL) * kill_num);
  end
`endif

endmodule

// File: tb/tb_goomba_slot_scheduler.sv
module tb_goomba_slot_scheduler;
  localparam int NS = 4;
  localparam int RH = 2;
  localparam int DC = 30;
  localparam int KX = 1000;
  localparam int PPK = 100;

  logic                 movement_clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 spawn_valid = 1'b0;
  logic                 spawn_ready;
  logic [31:0]          spawn_x = '0;
  logic [31:0]          spawn_y = '0;
  logic [NS-1:0][31:0]  goomba_x_slot = '0;
  logic [NS-1:0]        goomba_lose_slot = '0;
  logic [NS-1:0]        slot_reset_n;
  logic [NS-1:0][31:0]  slot_x_initial;
  logic [NS-1:0][31:0]  slot_y_initial;
  logic [NS-1:0]        slot_active;
  logic                 game_over;
  logic [15:0]          kill_count;
`ifdef GOOMBA_SCORE_EN
  logic [15:0]          score;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  goomba_slot_scheduler dut (
    .movement_clock   (movement_clock),
    .reset            (reset),
    .spawn_valid      (spawn_valid),
    .spawn_ready      (spawn_ready),
    .spawn_x          (spawn_x),
    .spawn_y          (spawn_y),
    .goomba_x_slot    (goomba_x_slot),
    .goomba_lose_slot (goomba_lose_slot),
    .slot_reset_n     (slot_reset_n),
    .slot_x_initial   (slot_x_initial),
    .slot_y_initial   (slot_y_initial),
    .slot_active      (slot_active),
    .game_over        (game_over),
    .kill_count       (kill_count)
`ifdef GOOMBA_SCORE_EN
    , .score          (score)
`endif
  );

  // ---------------- clock ----------------
  always #5 movement_clock = ~movement_clock;

  // ---------------- reference model ----------------
  // Each slot is described by timestamps: the edge it was allocated on and the
  // edge it was stomped on. Its status at time t follows from plain arithmetic.
  int          t;
  bit          m_busy   [NS];
  int          m_alloc_t[NS];
  int          m_kill_t [NS];
  logic [31:0] m_x      [NS];
  logic [31:0] m_y      [NS];
  bit          m_go;
  int          m_kills;
  int          m_score;

  function automatic bit m_is_free(int i);
    return !m_busy[i] || (m_kill_t[i] >= 0 && t >= m_kill_t[i] + DC);
  endfunction

  function automatic bit m_is_active(int i);
    return m_busy[i] && m_kill_t[i] < 0 && t >= m_alloc_t[i] + RH;
  endfunction

  function automatic bit m_ready();
    bit any = 0;
    for (int i = 0; i < NS; i++) if (m_is_free(i)) any = 1;
    return any && !m_go;
  endfunction

  function automatic logic [NS-1:0] m_active_vec();
    logic [NS-1:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_is_active(i);
    return v;
  endfunction

  task automatic model_reset();
    t = 0; m_go = 0; m_kills = 0; m_score = 0;
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 0; m_alloc_t[i] = 0; m_kill_t[i] = -1; m_x[i] = '0; m_y[i] = '0;
    end
  endtask

  task automatic model_step();
    bit ready, any_lose;
    int nk, pick;
    ready = m_ready(); any_lose = 0; nk = 0; pick = -1;
    for (int i = 0; i < NS; i++) if (pick < 0 && m_is_free(i)) pick = i;
    for (int i = 0; i < NS; i++) begin
      if (m_is_active(i)) begin
        if (goomba_lose_slot[i]) any_lose = 1;
        if (goomba_x_slot[i] == 32'(KX) && !m_go) begin
          nk++;
          m_kill_t[i] = t + 1;
        end
      end
    end
    if (spawn_valid && ready) begin
      m_busy[pick] = 1; m_alloc_t[pick] = t + 1; m_kill_t[pick] = -1;
      m_x[pick] = spawn_x; m_y[pick] = spawn_y;
    end
    if (!m_go && !any_lose) begin
      m_kills = (m_kills + nk > 65535) ? 65535 : m_kills + nk;
      m_score = (m_score + nk * PPK > 65535) ? 65535 : m_score + nk * PPK;
    end
    if (any_lose) m_go = 1;
    t++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_clock();
    @(posedge movement_clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spawn_valid = 1'b0;
    goomba_x_slot = '0;
    goomba_lose_slot = '0;
    @(posedge movement_clock);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic spawn_n(int n);
    spawn_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      spawn_x = 32'($urandom_range(0, 900));
      spawn_y = 32'($urandom_range(0, 480));
      step_clock();
    end
    spawn_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (slot_reset_n !== 4'b0000) begin n_fail++; $display("FAIL reset_slot_reset_n: got %b expected 0000", slot_reset_n); end
    n_tests++;
    if (slot_active !== 4'b0000) begin n_fail++; $display("FAIL reset_slot_active: got %b expected 0000", slot_active); end
    n_tests++;
    if (game_over !== 1'b0 || kill_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got go=%b kc=%0d expected 0/0", game_over, kill_count); end
    n_tests++;
    if (slot_x_initial !== '0 || slot_y_initial !== '0) begin n_fail++; $display("FAIL reset_initials: got x=%h y=%h expected 0", slot_x_initial, slot_y_initial); end
    n_tests++;
    if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_spawn_ready: got %b expected 1", spawn_ready); end
  endtask

  task automatic test_single_spawn();
    do_reset();
    spawn_valid = 1'b1; spawn_x = 32'd100; spawn_y = 32'd398;
    step_clock();
    spawn_valid = 1'b0;
    n_tests++;
    if (slot_x_initial[0] !== 32'd100 || slot_y_initial[0] !== 32'd398) begin
      n_fail++; $display("FAIL single_initials: got %0d/%0d expected 100/398", slot_x_initial[0], slot_y_initial[0]);
    end
    for (int c = 0; c < RH; c++) begin
      n_tests++;
      if (slot_reset_n !== 4'b0000 || slot_active !== 4'b0000) begin
        n_fail++; $display("FAIL single_hold_c%0d: got rn=%b act=%b expected 0000/0000", c, slot_reset_n, slot_active);
      end
      if (c < RH - 1) step_clock();
    end
    step_clock();
    n_tests++;
    if (slot_reset_n !== 4'b0001 || slot_active !== 4'b0001) begin
      n_fail++; $display("FAIL single_active: got rn=%b act=%b expected 0001/0001", slot_reset_n, slot_active);
    end
  endtask

  task automatic test_fill_and_kill();
    int dying;
    do_reset();
    spawn_valid = 1'b1;
    for (int k = 0; k < NS; k++) begin
      spawn_x = 32'(200 + k); spawn_y = 32'(10 * k);
      n_tests++;
      if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", k, spawn_ready); end
      step_clock();
      n_tests++;
      if (slot_x_initial[k] !== 32'(200 + k) || slot_y_initial[k] !== 32'(10 * k)) begin
        n_fail++; $display("FAIL fill_slot_%0d: got %0d/%0d expected %0d/%0d", k, slot_x_initial[k], slot_y_initial[k], 200 + k, 10 * k);
      end
    end
    // fifth request held while the pool is full
    spawn_x = 32'd555; spawn_y = 32'd7;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL fifth_not_ready_c%0d: got %b expected 0", c, spawn_ready); end
      step_clock();
    end
    n_tests++;
    if (slot_active !== 4'b1111) begin n_fail++; $display("FAIL fill_all_active: got %b expected 1111", slot_active); end
    goomba_x_slot[1] = 32'(KX);
    step_clock();
    n_tests++;
    if (kill_count !== 16'd1 || slot_active !== 4'b1101) begin
      n_fail++; $display("FAIL kill_one: got kc=%0d act=%b expected 1/1101", kill_count, slot_active);
    end
`ifdef GOOMBA_SCORE_EN
    n_tests++;
    if (score !== 16'd100) begin n_fail++; $display("FAIL score_one_kill: got %0d expected 100", score); end
`endif
    // stale KILL_X during DYING must not count again
    dying = 1;
    while (spawn_ready !== 1'b1 && dying < 60) begin
      if (dying == 5) goomba_x_slot[1] = 32'd0;
      step_clock();
      if (spawn_ready !== 1'b1) dying++;
    end
    n_tests++;
    if (dying != DC) begin n_fail++; $display("FAIL dying_length: got %0d expected %0d", dying, DC); end
    n_tests++;
    if (kill_count !== 16'(m_kills) || m_kills != 1) begin n_fail++; $display("FAIL stale_kill_masked: got %0d expected 1", kill_count); end
    step_clock();
    spawn_valid = 1'b0;
    n_tests++;
    if (slot_x_initial[1] !== 32'd555 || slot_y_initial[1] !== 32'd7 || spawn_ready !== 1'b0) begin
      n_fail++; $display("FAIL respawn_slot1: got %0d/%0d ready=%b expected 555/7 ready=0", slot_x_initial[1], slot_y_initial[1], spawn_ready);
    end
  endtask

  task automatic test_double_kill();
    do_reset();
    spawn_n(3);
    for (int c = 0; c < RH; c++) step_clock();
    goomba_x_slot[0] = 32'(KX);
    goomba_x_slot[2] = 32'(KX);
    step_clock();
    goomba_x_slot = '0;
    n_tests++;
    if (kill_count !== 16'd2 || slot_active !== 4'b0010) begin
      n_fail++; $display("FAIL double_kill: got kc=%0d act=%b expected 2/0010", kill_count, slot_active);
    end
`ifdef GOOMBA_SCORE_EN
    n_tests++;
    if (score !== 16'd200) begin n_fail++; $display("FAIL score_double: got %0d expected 200", score); end
`endif
    n_tests++;
    if (goomba_pkg::sat_add16(16'hFFFE, 32'd2) !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_add16_saturate: got %h expected ffff", goomba_pkg::sat_add16(16'hFFFE, 32'd2));
    end
    n_tests++;
    if (goomba_pkg::sat_add16(16'hFFFE, 32'd1) !== 16'hFFFF || goomba_pkg::sat_add16(16'h0010, 32'd3) !== 16'h0013) begin
      n_fail++; $display("FAIL sat_add16_plain: got %h/%h expected ffff/0013",
                         goomba_pkg::sat_add16(16'hFFFE, 32'd1), goomba_pkg::sat_add16(16'h0010, 32'd3));
    end
  endtask

  task automatic test_kill_and_lose();
    do_reset();
    spawn_n(4);
    for (int c = 0; c < RH; c++) step_clock();
    goomba_lose_slot[0] = 1'b1;
    goomba_x_slot[3] = 32'(KX);
    step_clock();
    goomba_lose_slot = '0;
    goomba_x_slot = '0;
    n_tests++;
    if (game_over !== 1'b1 || kill_count !== 16'd0 || spawn_ready !== 1'b0 || slot_active !== 4'b0111) begin
      n_fail++; $display("FAIL kill_lose_same: got go=%b kc=%0d rdy=%b act=%b expected 1/0/0/0111", game_over, kill_count, spawn_ready, slot_active);
    end
    // frozen: kills no longer counted, ACTIVE stays ACTIVE, spawns refused
    goomba_x_slot[1] = 32'(KX);
    spawn_valid = 1'b1;
    for (int c = 0; c < DC + 3; c++) step_clock();
    goomba_x_slot = '0;
    spawn_valid = 1'b0;
    n_tests++;
    if (game_over !== 1'b1 || kill_count !== 16'd0 || slot_active !== 4'b0111 || spawn_ready !== 1'b0) begin
      n_fail++; $display("FAIL frozen_after_go: got go=%b kc=%0d act=%b rdy=%b expected 1/0/0111/0", game_over, kill_count, slot_active, spawn_ready);
    end
    do_reset();
    n_tests++;
    if (game_over !== 1'b0 || spawn_ready !== 1'b1) begin
      n_fail++; $display("FAIL go_cleared_by_reset: got go=%b rdy=%b expected 0/1", game_over, spawn_ready);
    end
  endtask

  task automatic test_lose_masked();
    do_reset();
    goomba_lose_slot = 4'b1111;
    step_clock();
    step_clock();
    n_tests++;
    if (game_over !== 1'b0) begin n_fail++; $display("FAIL lose_on_free: got %b expected 0", game_over); end
    spawn_n(1);
    for (int c = 0; c < RH; c++) step_clock();
    n_tests++;
    if (game_over !== 1'b0 || slot_active !== 4'b0001) begin
      n_fail++; $display("FAIL lose_on_load: got go=%b act=%b expected 0/0001", game_over, slot_active);
    end
    step_clock();
    goomba_lose_slot = '0;
    n_tests++;
    if (game_over !== 1'b1) begin n_fail++; $display("FAIL lose_on_active: got %b expected 1", game_over); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      spawn_valid = ($urandom_range(0, 2) != 0);
      spawn_x = 32'($urandom_range(0, 2000));
      spawn_y = 32'($urandom_range(0, 480));
      for (int i = 0; i < NS; i++) begin
        goomba_x_slot[i] = ($urandom_range(0, 7) == 0) ? 32'(KX) : 32'($urandom_range(0, 999));
        goomba_lose_slot[i] = ($urandom_range(0, 499) == 0);
      end
      step_clock();
      n_tests++;
      if (spawn_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", n, spawn_ready, m_ready()); end
      n_tests++;
      if (slot_active !== m_active_vec() || slot_reset_n !== m_active_vec()) begin
        n_fail++; $display("FAIL rand_active@%0d: got act=%b rn=%b expected %b", n, slot_active, slot_reset_n, m_active_vec());
      end
      n_tests++;
      if (game_over !== m_go || kill_count !== 16'(m_kills)) begin
        n_fail++; $display("FAIL rand_go_kc@%0d: got %b/%0d expected %b/%0d", n, game_over, kill_count, m_go, m_kills);
      end
`ifdef GOOMBA_SCORE_EN
      n_tests++;
      if (score !== 16'(m_score)) begin n_fail++; $display("FAIL rand_score@%0d: got %0d expected %0d", n, score, m_score); end
`endif
      for (int i = 0; i < NS; i++) begin
        n_tests++;
        if (slot_x_initial[i] !== m_x[i] || slot_y_initial[i] !== m_y[i]) begin
          n_fail++; $display("FAIL rand_init%0d@%0d: got %0d/%0d expected %0d/%0d", i, n, slot_x_initial[i], slot_y_initial[i], m_x[i], m_y[i]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_spawn();
    test_fill_and_kill();
    test_double_kill();
    test_kill_and_lose();
    test_lose_masked();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
